// File: rtl/rv32_fetch_pkg.sv
// rtl/rv32_fetch_pkg.sv - shared widths, constants and state encoding for the fetch stage
//
// Purpose: common definitions imported by fetch_unit.
// Contents: XLEN / ILEN widths, PC_STEP sequential increment, fetch_state_e FSM encoding.
package rv32_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;

    // ISSUE: a request is (or may be) presented to instruction memory.
    // WAIT : exactly one request is outstanding, awaiting its response.
    typedef enum logic {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - plain modular adder used for the sequential PC increment
//
// Purpose: sum = a + b, truncated to operand_width (wraps modulo 2^operand_width).
// Ports:
//   a   in  operand_width : first operand
//   b   in  operand_width : second operand
//   sum out operand_width : a + b
module adder #(
    parameter int operand_width = 32
) (
    input  logic [operand_width-1:0] a,
    input  logic [operand_width-1:0] b,
    output logic [operand_width-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch stage with one-entry decode buffer
//
// Purpose: holds the architectural PC, issues one word fetch at a time over a
// valid/ready request channel and hands fetched instructions to decode through
// a one-entry buffer. Redirects squash in-flight and buffered instructions.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   redirect_valid, redirect_pc    : taken branch/jump and its target
//   imem_req_valid/addr/ready      : fetch request channel (addr = PC)
//   imem_resp_valid/data           : response for the single outstanding request
//   id_valid/pc/instr              : buffered instruction presented to decode
//   id_ready                       : decode consumes on id_valid && id_ready
module fetch_unit
    import rv32_fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req_valid,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [ILEN-1:0]  imem_resp_data,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [ILEN-1:0]  id_instr,
    input  logic             id_ready
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus_step;
    logic [XLEN-1:0]  req_pc;
    logic             drop;

    logic             buf_free;
    logic             accept;
    logic             consume;
    logic             resp_load;

    adder #(
        .operand_width (XLEN)
    ) u_pc_adder (
        .a   (pc),
        .b   (XLEN'(PC_STEP)),
        .sum (pc_plus_step)
    );

    // The buffer can take a new instruction if it is empty or is being
    // drained this cycle; requesting earlier could leave a response nowhere
    // to land.
    assign consume        = id_valid && id_ready;
    assign buf_free       = !id_valid || id_ready;
    assign imem_req_valid = !rst && (state == ISSUE) && buf_free;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response is written to the buffer only if it belongs to the current
    // instruction stream: not flagged for dropping and not squashed by a
    // redirect arriving in the same cycle.
    assign resp_load = (state == WAIT) && imem_resp_valid && !drop && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ISSUE;
        end else begin
            state <= state_next;
        end
    end

    // Redirects never alter the state sequence; they only redirect pc and
    // mark the outstanding response for dropping.
    always_comb begin
        state_next = state;
        case (state)
            ISSUE: if (accept)          state_next = WAIT;
            WAIT:  if (imem_resp_valid) state_next = ISSUE;
            default:                    state_next = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= '0;
        end else begin
            if (accept) begin
                req_pc <= pc;
            end

            if (redirect_valid) begin
                pc <= redirect_pc & ALIGN_MASK;
            end else if (accept) begin
                pc <= pc_plus_step;
            end

            // drop marks the single outstanding response as stale.
            if (state == ISSUE) begin
                if (accept && redirect_valid) begin
                    drop <= 1'b1;
                end
            end else begin
                if (imem_resp_valid) begin
                    drop <= 1'b0;
                end else if (redirect_valid) begin
                    drop <= 1'b1;
                end
            end

            if (redirect_valid) begin
                id_valid <= 1'b0;
            end else if (resp_load) begin
                id_valid <= 1'b1;
            end else if (consume) begin
                id_valid <= 1'b0;
            end

            if (resp_load) begin
                id_pc    <= req_pc;
                id_instr <= imem_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          mem_k    = 1;
    int          n;
    logic [31:0] req_log[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_instr        (id_instr),
        .id_ready        (id_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: samples the request mid-cycle, answers mem_k cycles
    // after the accepting edge, and is reset together with the core.
    logic        mem_pending = 1'b0;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        acc;
    logic [31:0] acc_addr;
    logic        rst_seen;

    always begin
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rst_seen = rst;
        if (acc && !rst) req_log.push_back(acc_addr);
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (rst_seen) begin
            mem_pending = 1'b0;
        end else begin
            if (acc) begin
                mem_pending = 1'b1;
                mem_cnt     = mem_k;
                mem_addr    = acc_addr;
            end
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = instr_of(mem_addr);
                    mem_pending     = 1'b0;
                end
            end
        end
    end

    task automatic next_cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until id_valid is seen; cycles advanced are returned.
    task automatic wait_id(output int cycles);
        cycles = 0;
        #1;
        while (id_valid !== 1'b1 && cycles < 50) begin
            next_cyc;
            #1;
            cycles++;
        end
        chk("wait_id_valid", {31'b0, id_valid}, 32'd1);
    endtask

    task automatic do_reset;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        next_cyc;
        next_cyc;
        req_log.delete();
        next_cyc;
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        mem_k          = 1;

        // Reset state
        next_cyc;
        next_cyc;
        #1;
        chk("rst_id_valid",  {31'b0, id_valid},       32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_id_pc",     id_pc,                   32'h0);
        chk("rst_id_instr",  id_instr,                32'h0);

        // Sequential stream at k=1 with decode always ready
        next_cyc;
        rst = 1'b0;
        #1;
        chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_req_addr",  imem_req_addr,           32'h0);
        wait_id(n);
        chk("t1_latency",   32'(n),   32'd2);
        chk("t1_pc0",       id_pc,    32'h0);
        chk("t1_instr0",    id_instr, instr_of(32'h0));
        next_cyc;
        wait_id(n);
        chk("t1_gap1",      32'(n),   32'd1);
        chk("t1_pc1",       id_pc,    32'h4);
        chk("t1_instr1",    id_instr, instr_of(32'h4));
        next_cyc;
        wait_id(n);
        chk("t1_pc2",       id_pc,    32'h8);
        chk("t1_instr2",    id_instr, instr_of(32'h8));
        chk("t1_log_size",  32'(req_log.size()), 32'd3);
        chk("t1_log1",      req_log[1], 32'h4);
        chk("t1_log2",      req_log[2], 32'h8);

        // Decode stalled for 5 cycles after the first instruction
        id_ready = 1'b0;
        do_reset;
        wait_id(n);
        chk("t2_pc0",        id_pc, 32'h0);
        chk("t2_req_stall",  {31'b0, imem_req_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            next_cyc;
            #1;
            chk("t2_hold_valid", {31'b0, id_valid},       32'd1);
            chk("t2_hold_pc",    id_pc,                   32'h0);
            chk("t2_hold_req",   {31'b0, imem_req_valid}, 32'd0);
        end
        next_cyc;
        id_ready = 1'b1;
        #1;
        chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t2_req_addr",  imem_req_addr,           32'h4);
        next_cyc;
        #1;
        chk("t2_consumed",  {31'b0, id_valid},       32'd0);

        // Redirect while WAIT with k=3: stale response discarded
        id_ready = 1'b1;
        mem_k    = 3;
        do_reset;
        next_cyc;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_wait_noreq", {31'b0, imem_req_valid}, 32'd0);
        next_cyc;
        redirect_valid = 1'b0;
        wait_id(n);
        chk("t3_latency",   32'(n),   32'd6);
        chk("t3_pc",        id_pc,    32'h100);
        chk("t3_instr",     id_instr, instr_of(32'h100));
        chk("t3_log_size",  32'(req_log.size()), 32'd2);
        chk("t3_log1",      req_log[1], 32'h100);

        // Redirect to unaligned 0x203 while buffer holds 0x8
        mem_k = 1;
        do_reset;
        wait_id(n);
        next_cyc;
        wait_id(n);
        chk("t4_pc4",       id_pc, 32'h4);
        next_cyc;
        id_ready = 1'b0;
        next_cyc;
        #1;
        chk("t4_buf_valid", {31'b0, id_valid}, 32'd1);
        chk("t4_buf_pc",    id_pc,             32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        next_cyc;
        redirect_valid = 1'b0;
        #1;
        chk("t4_squash",    {31'b0, id_valid},       32'd0);
        chk("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t4_req_addr",  imem_req_addr,           32'h200);

        // Redirect in the same cycle as the response
        id_ready = 1'b1;
        do_reset;
        next_cyc;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        next_cyc;
        redirect_valid = 1'b0;
        #1;
        chk("t5_no_deliver", {31'b0, id_valid},       32'd0);
        chk("t5_req_valid",  {31'b0, imem_req_valid}, 32'd1);
        chk("t5_req_addr",   imem_req_addr,           32'h300);
        wait_id(n);
        chk("t5_latency",    32'(n), 32'd2);
        chk("t5_pc",         id_pc,  32'h300);

        // Reset pulse with buffer full and pc = 0x40
        id_ready = 1'b0;
        do_reset;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3C;
        next_cyc;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("t6_req_addr_tgt", imem_req_addr, 32'h3C);
        wait_id(n);
        chk("t6_pc",        id_pc,         32'h3C);
        chk("t6_pc_reg",    imem_req_addr, 32'h40);
        rst = 1'b1;
        next_cyc;
        rst = 1'b0;
        #1;
        chk("t6_id_cleared", {31'b0, id_valid},       32'd0);
        chk("t6_req_valid",  {31'b0, imem_req_valid}, 32'd1);
        chk("t6_req_restart", imem_req_addr,          32'h0);

        // PC wrap from 0xFFFF_FFFC
        id_ready = 1'b1;
        do_reset;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        next_cyc;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_id(n);
        chk("t7_pc",        id_pc,    32'hFFFF_FFFC);
        chk("t7_instr",     id_instr, instr_of(32'hFFFF_FFFC));
        chk("t7_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t7_wrap_addr", imem_req_addr,           32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
